// File: rtl/btb_assoc_if.sv
// Fetch/writeback bus of the set-associative branch target buffer.
// master = pipeline side, slave = BTB side.
interface btb_assoc_if #(
    parameter int WIDTH = 16
);
    logic             lookup_en;
    logic [WIDTH-1:0] lookup_pc;
    logic             pred_valid;
    logic             pred_hit;
    logic             pred_taken;
    logic [WIDTH-1:0] pred_target;
    logic             upd_en;
    logic [WIDTH-1:0] upd_pc;
    logic [WIDTH-1:0] upd_target;
    logic             upd_taken;
    logic             flush;
    logic             busy;

    modport master (
        output lookup_en, lookup_pc, upd_en, upd_pc, upd_target, upd_taken, flush,
        input  pred_valid, pred_hit, pred_taken, pred_target, busy
    );

    modport slave (
        input  lookup_en, lookup_pc, upd_en, upd_pc, upd_target, upd_taken, flush,
        output pred_valid, pred_hit, pred_taken, pred_target, busy
    );
endinterface

// File: rtl/btb_assoc.sv
// Set-associative BTB with saturating direction counters, tree pseudo-LRU
// replacement, one-cycle registered lookup and a set-by-set flush sequencer.
module btb_assoc #(
    parameter int WIDTH    = 16,
    parameter int SETS     = 8,
    parameter int WAYS     = 4,
    parameter int CTR_BITS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    btb_assoc_if.slave  bus
);
    localparam int IDX   = $clog2(SETS);
    localparam int LW    = $clog2(WAYS);
    localparam int TAG_W = WIDTH - IDX - 1;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

    typedef enum logic {S_IDLE, S_FLUSH} state_t;

    state_t r_state, w_state_next;
    logic   w_busy;
    logic   w_clear;

    logic [IDX-1:0]      r_cnt;
    logic [WAYS-1:0]     r_valid  [SETS];
    logic [WAYS-2:0]     r_plru   [SETS];
    logic [TAG_W-1:0]    r_tag    [SETS][WAYS];
    logic [WIDTH-1:0]    r_target [SETS][WAYS];
    logic [CTR_BITS-1:0] r_ctr    [SETS][WAYS];

    logic             r_pred_valid, r_pred_hit, r_pred_taken;
    logic [WIDTH-1:0] r_pred_target;

    logic [IDX-1:0]   w_lk_idx, w_up_idx;
    logic [TAG_W-1:0] w_lk_tag, w_up_tag;
    logic [WAYS-1:0]  w_lk_hitv, w_up_hitv;
    logic [LW-1:0]    w_lk_way, w_up_way;
    logic             w_lk_hit, w_up_hit, w_up_write;
    logic [CTR_BITS-1:0] w_ctr_next;
    logic             w_unused;

    function automatic logic [LW-1:0] first_one(input logic [WAYS-1:0] v);
        logic [LW-1:0] r;
        r = '0;
        for (int i = WAYS - 1; i >= 0; i--)
            if (v[i]) r = LW'(i);
        return r;
    endfunction

    // Walk from the root following node bits (0 = lower half) to the victim leaf.
    function automatic logic [LW-1:0] plru_victim(input logic [WAYS-2:0] b);
        int node;
        node = 0;
        for (int l = 0; l < LW; l++)
            node = 2 * node + 1 + int'(b[node]);
        return LW'(node - (WAYS - 1));
    endfunction

    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] b,
                                                   input logic [LW-1:0]   w);
        logic [WAYS-2:0] r;
        int node;
        r    = b;
        node = 0;
        for (int l = 0; l < LW; l++) begin
            r[node] = ~w[LW-1-l];
            node    = 2 * node + 1 + int'(w[LW-1-l]);
        end
        return r;
    endfunction

    assign w_lk_idx = bus.lookup_pc[IDX:1];
    assign w_lk_tag = bus.lookup_pc[WIDTH-1:IDX+1];
    assign w_up_idx = bus.upd_pc[IDX:1];
    assign w_up_tag = bus.upd_pc[WIDTH-1:IDX+1];
    assign w_unused = ^{bus.lookup_pc[0], bus.upd_pc[0]};

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            assign w_lk_hitv[gi] = r_valid[w_lk_idx][gi] && (r_tag[w_lk_idx][gi] == w_lk_tag);
            assign w_up_hitv[gi] = r_valid[w_up_idx][gi] && (r_tag[w_up_idx][gi] == w_up_tag);
        end
    endgenerate

    assign w_lk_way   = first_one(w_lk_hitv);
    assign w_lk_hit   = bus.lookup_en && !w_busy && (|w_lk_hitv);
    assign w_up_hit   = |w_up_hitv;
    assign w_up_write = bus.upd_en && !w_busy && (w_up_hit || bus.upd_taken);

    always_comb begin
        w_up_way   = plru_victim(r_plru[w_up_idx]);
        w_ctr_next = CTR_WEAK;
        if (w_up_hit) begin
            w_up_way = first_one(w_up_hitv);
        end else if (~&r_valid[w_up_idx]) begin
            w_up_way = first_one(~r_valid[w_up_idx]);
        end
        if (w_up_hit) begin
            w_ctr_next = r_ctr[w_up_idx][w_up_way];
            if (bus.upd_taken && w_ctr_next != CTR_MAX)
                w_ctr_next = w_ctr_next + 1'b1;
            else if (!bus.upd_taken && w_ctr_next != '0)
                w_ctr_next = w_ctr_next - 1'b1;
        end
    end

    // Flush sequencer: state register / next state / outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.flush) w_state_next = S_FLUSH;
            S_FLUSH: if (r_cnt == IDX'(SETS - 1)) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy  = (r_state == S_FLUSH);
        w_clear = (r_state == S_FLUSH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_pred_valid  <= 1'b0;
            r_pred_hit    <= 1'b0;
            r_pred_taken  <= 1'b0;
            r_pred_target <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_plru[s]  <= '0;
            end
        end else begin
            r_pred_valid  <= bus.lookup_en;
            r_pred_hit    <= w_lk_hit;
            r_pred_taken  <= w_lk_hit && r_ctr[w_lk_idx][w_lk_way][CTR_BITS-1];
            r_pred_target <= w_lk_hit ? r_target[w_lk_idx][w_lk_way] : '0;
            if (w_clear) begin
                r_valid[r_cnt] <= '0;
                r_plru[r_cnt]  <= '0;
                if (r_cnt != IDX'(SETS - 1))
                    r_cnt <= r_cnt + 1'b1;
            end else begin
                if (bus.flush)
                    r_cnt <= '0;
                if (w_up_write) begin
                    r_valid[w_up_idx][w_up_way] <= 1'b1;
                    r_plru[w_up_idx] <= plru_touch(r_plru[w_up_idx], w_up_way);
                end
                // The update's touch takes precedence when both land in one set.
                if (w_lk_hit && !(w_up_write && w_up_idx == w_lk_idx))
                    r_plru[w_lk_idx] <= plru_touch(r_plru[w_lk_idx], w_lk_way);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_up_write) begin
            if (!w_up_hit)
                r_tag[w_up_idx][w_up_way] <= w_up_tag;
            if (bus.upd_taken)
                r_target[w_up_idx][w_up_way] <= bus.upd_target;
            r_ctr[w_up_idx][w_up_way] <= w_ctr_next;
        end
    end

    assign bus.pred_valid  = r_pred_valid;
    assign bus.pred_hit    = r_pred_hit;
    assign bus.pred_taken  = r_pred_taken;
    assign bus.pred_target = r_pred_target;
    assign bus.busy        = w_busy;
endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc: directed scenarios plus random traffic
// compared every cycle against a behavioural BTB model.
module tb_btb_assoc;
    localparam int WIDTH    = 16;
    localparam int SETS     = 8;
    localparam int WAYS     = 4;
    localparam int CTR_BITS = 2;
    localparam int IDX      = $clog2(SETS);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    btb_assoc_if #(.WIDTH(WIDTH)) bus ();

    btb_assoc #(.WIDTH(WIDTH), .SETS(SETS), .WAYS(WAYS), .CTR_BITS(CTR_BITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit m_valid [SETS][WAYS];
    int m_tag   [SETS][WAYS];
    int m_tgt   [SETS][WAYS];
    int m_ctr   [SETS][WAYS];
    bit m_plru  [SETS][WAYS-1];
    int m_fs;
    int e_valid, e_hit, e_taken, e_target, e_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int set_of(input int pc);
        return (pc >> 1) % SETS;
    endfunction

    function automatic int tag_of(input int pc);
        return pc >> (IDX + 1);
    endfunction

    task automatic m_touch(input int s, input int w);
        int lo, hi, node, mid;
        lo = 0; hi = WAYS; node = 0;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (w < mid) begin m_plru[s][node] = 1'b1; node = 2*node + 1; hi = mid; end
            else         begin m_plru[s][node] = 1'b0; node = 2*node + 2; lo = mid; end
        end
    endtask

    function automatic int m_victim(input int s);
        int lo, hi, node, mid;
        lo = 0; hi = WAYS; node = 0;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (m_plru[s][node] == 1'b0) begin node = 2*node + 1; hi = mid; end
            else                         begin node = 2*node + 2; lo = mid; end
        end
        return lo;
    endfunction

    function automatic int m_find(input int pc);
        int s;
        s = set_of(pc);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == tag_of(pc)) return w;
        return -1;
    endfunction

    task automatic m_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
            for (int n = 0; n < WAYS-1; n++) m_plru[s][n] = 1'b0;
        end
        m_fs = -1;
        e_valid = 0; e_hit = 0; e_taken = 0; e_target = 0; e_busy = 0;
    endtask

    // Model reaction to one rising edge, from the inputs presented at that edge.
    task automatic m_edge();
        int lk_w, lk_s, up_s, s, w, maxc;
        if (!rst_n) begin
            m_reset();
            return;
        end
        maxc = (1 << CTR_BITS) - 1;
        lk_s = set_of(int'(bus.lookup_pc));
        lk_w = (bus.lookup_en && m_fs < 0) ? m_find(int'(bus.lookup_pc)) : -1;
        e_valid  = bus.lookup_en ? 1 : 0;
        e_hit    = (lk_w >= 0) ? 1 : 0;
        e_taken  = (lk_w >= 0 && m_ctr[lk_s][lk_w] >= (1 << (CTR_BITS-1))) ? 1 : 0;
        e_target = (lk_w >= 0) ? m_tgt[lk_s][lk_w] : 0;
        if (m_fs >= 0) begin
            for (int k = 0; k < WAYS; k++) m_valid[m_fs][k] = 1'b0;
            for (int n = 0; n < WAYS-1; n++) m_plru[m_fs][n] = 1'b0;
            m_fs++;
            if (m_fs == SETS) m_fs = -1;
        end else begin
            up_s = -1;
            if (bus.upd_en) begin
                s = set_of(int'(bus.upd_pc));
                w = m_find(int'(bus.upd_pc));
                if (w >= 0) begin
                    if (bus.upd_taken) begin
                        m_ctr[s][w] = (m_ctr[s][w] < maxc) ? m_ctr[s][w] + 1 : maxc;
                        m_tgt[s][w] = int'(bus.upd_target);
                    end else begin
                        m_ctr[s][w] = (m_ctr[s][w] > 0) ? m_ctr[s][w] - 1 : 0;
                    end
                    m_touch(s, w);
                    up_s = s;
                end else if (bus.upd_taken) begin
                    w = -1;
                    for (int k = WAYS - 1; k >= 0; k--) if (!m_valid[s][k]) w = k;
                    if (w < 0) w = m_victim(s);
                    m_valid[s][w] = 1'b1;
                    m_tag[s][w]   = tag_of(int'(bus.upd_pc));
                    m_tgt[s][w]   = int'(bus.upd_target);
                    m_ctr[s][w]   = 1 << (CTR_BITS - 1);
                    m_touch(s, w);
                    up_s = s;
                end
            end
            if (lk_w >= 0 && lk_s != up_s) m_touch(lk_s, lk_w);
            if (bus.flush) m_fs = 0;
        end
        e_busy = (m_fs >= 0) ? 1 : 0;
    endtask

    task automatic compare();
        chk("pred_valid",  bus.pred_valid,  e_valid);
        chk("pred_hit",    bus.pred_hit,    e_hit);
        chk("pred_taken",  bus.pred_taken,  e_taken);
        chk("pred_target", bus.pred_target, e_target);
        chk("busy",        bus.busy,        e_busy);
    endtask

    task automatic step();
        @(posedge clk);
        m_edge();
        #1;
        compare();
    endtask

    task automatic cyc(input bit le, input int lpc, input bit ue, input int upc,
                       input int utgt, input bit utk, input bit fl);
        bus.lookup_en  = le;
        bus.lookup_pc  = WIDTH'(lpc);
        bus.upd_en     = ue;
        bus.upd_pc     = WIDTH'(upc);
        bus.upd_target = WIDTH'(utgt);
        bus.upd_taken  = utk;
        bus.flush      = fl;
        step();
        bus.lookup_en = 1'b0;
        bus.upd_en    = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic upd(input int pc, input int tgt, input bit tk);
        cyc(1'b0, 0, 1'b1, pc, tgt, tk, 1'b0);
    endtask

    task automatic lk(input string name, input int pc, input bit hit, input bit tk, input int tgt);
        cyc(1'b1, pc, 1'b0, 0, 0, 1'b0, 1'b0);
        chk({name, "_hit"},    bus.pred_hit,    hit);
        chk({name, "_taken"},  bus.pred_taken,  tk);
        chk({name, "_target"}, bus.pred_target, tgt);
    endtask

    initial begin
        int nbusy;
        bus.lookup_en = 1'b0; bus.lookup_pc = '0;
        bus.upd_en = 1'b0; bus.upd_pc = '0; bus.upd_target = '0; bus.upd_taken = 1'b0;
        bus.flush = 1'b0;
        m_reset();
        step();
        step();
        rst_n = 1'b1;

        // Reset state and first lookup
        lk("t1_lookup", 16'h3000, 1'b0, 1'b0, 0);
        chk("t1_valid", bus.pred_valid, 1);
        cyc(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
        chk("t1_idle_valid", bus.pred_valid, 0);

        // Allocate and hit
        upd(16'h3000, 16'h3040, 1'b1);
        lk("t2_hit", 16'h3000, 1'b1, 1'b1, 16'h3040);
        lk("t2_other_set", 16'h3002, 1'b0, 1'b0, 0);

        // Counter saturation at zero; not-taken miss does not allocate
        upd(16'h3000, 0, 1'b0);
        upd(16'h3000, 0, 1'b0);
        lk("t3_nt", 16'h3000, 1'b1, 1'b0, 16'h3040);
        upd(16'h3000, 0, 1'b0);
        upd(16'h3000, 16'h3050, 1'b1);
        lk("t3_sat", 16'h3000, 1'b1, 1'b0, 16'h3050);
        upd(16'h3100, 16'h3200, 1'b0);
        lk("t3_nt_miss", 16'h3100, 1'b0, 1'b0, 0);

        // PLRU eviction in set 0
        upd(16'h3000, 16'h4000, 1'b1);
        upd(16'h3010, 16'h4010, 1'b1);
        upd(16'h3020, 16'h4020, 1'b1);
        upd(16'h3030, 16'h4030, 1'b1);
        lk("t4_touch", 16'h3000, 1'b1, 1'b1, 16'h4000);
        upd(16'h3040, 16'h4040, 1'b1);
        lk("t4_evicted", 16'h3020, 1'b0, 1'b0, 0);
        lk("t4_w0", 16'h3000, 1'b1, 1'b1, 16'h4000);
        lk("t4_w1", 16'h3010, 1'b1, 1'b1, 16'h4010);
        lk("t4_w3", 16'h3030, 1'b1, 1'b1, 16'h4030);
        lk("t4_new", 16'h3040, 1'b1, 1'b1, 16'h4040);

        // Flush: busy for SETS cycles, lookups miss, updates ignored
        upd(16'h300A, 16'h5000, 1'b1);
        cyc(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
        nbusy = bus.busy ? 1 : 0;
        for (int i = 0; i < 20 && bus.busy; i++) begin
            if (i == 1)      cyc(1'b1, 16'h3000, 1'b0, 0, 0, 1'b0, 1'b0);
            else if (i == 2) cyc(1'b0, 0, 1'b1, 16'h3000, 16'h6000, 1'b1, 1'b0);
            else             cyc(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
            if (bus.busy) nbusy++;
        end
        chk("t5_busy_cycles", nbusy, SETS);
        lk("t5_after_3000", 16'h3000, 1'b0, 1'b0, 0);
        lk("t5_after_300A", 16'h300A, 1'b0, 1'b0, 0);
        lk("t5_after_3040", 16'h3040, 1'b0, 1'b0, 0);

        // Same-cycle lookup and allocation: read-before-write
        cyc(1'b1, 16'h300A, 1'b1, 16'h300A, 16'h5100, 1'b1, 1'b0);
        chk("t6_rbw_hit", bus.pred_hit, 0);
        lk("t6_after", 16'h300A, 1'b1, 1'b1, 16'h5100);

        // Asynchronous reset in the middle of a flush
        cyc(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
        cyc(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
        cyc(1'b1, 16'h3000, 1'b0, 0, 0, 1'b0, 1'b0);
        chk("t6_busy_before_rst", bus.busy, 1);
        rst_n = 1'b0;
        #2;
        m_reset();
        compare();
        step();
        rst_n = 1'b1;
        lk("t6_rst_300A", 16'h300A, 1'b0, 1'b0, 0);
        lk("t6_rst_3000", 16'h3000, 1'b0, 1'b0, 0);

        // Random traffic over a small PC pool to force conflicts and evictions
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 9) < 6, 16'h3000 + 2 * $urandom_range(0, 47),
                $urandom_range(0, 1) == 1, 16'h3000 + 2 * $urandom_range(0, 47),
                $urandom_range(0, 16'hFFFF), $urandom_range(0, 9) < 6,
                $urandom_range(0, 99) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
- Parametrised set-associative branch target buffer for the LC-3b pipeline.
- Successor to the fixed 4-way BTB; adds configurable sets, ways and counter width.
- Adds per-entry saturating direction counters, tree pseudo-LRU replacement, registered lookup and a multi-cycle flush sequencer.
- Fetch stage issues lookups; writeback issues resolved-branch updates.

Parameters:
- WIDTH, 16: address and target width.
- SETS, 8: number of sets; power of 2, at least 2. IDX = log2(SETS).
- WAYS, 4: associativity; power of 2, at least 2.
- CTR_BITS, 2: direction counter width, at least 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- lookup_en  in  1  lookup request this cycle.
- lookup_pc  in  WIDTH  fetch PC.
- pred_valid  out  1  registered; result of the previous cycle's lookup is valid.
- pred_hit  out  1  lookup matched a valid entry.
- pred_taken  out  1  hit and counter MSB = 1.
- pred_target  out  WIDTH  stored target on hit, else 0.
- upd_en  in  1  resolved branch update.
- upd_pc  in  WIDTH  branch PC.
- upd_target  in  WIDTH  resolved target.
- upd_taken  in  1  branch outcome.
- flush  in  1  one-cycle flush request.
- busy  out  1  flush in progress.

Behaviour:
- Addressing:
  - index = pc[IDX:1] (word aligned; bit 0 ignored).
  - tag = pc[WIDTH-1:IDX+1].
- Storage per entry: valid, tag, target, ctr[CTR_BITS]. Per set: WAYS-1 tree-PLRU bits.
- Reset:
  - All valid bits, PLRU bits and state cleared asynchronously.
  - pred_valid, pred_hit, pred_taken, pred_target = 0; busy = 0.
  - Tag, target and ctr arrays are not reset.
- Lookup (latency 1):
  - lookup_en in cycle N produces outputs in cycle N+1.
  - pred_valid = 1 for exactly one cycle per lookup; all pred_* = 0 when pred_valid = 0.
  - On hit, the hit way's PLRU path is touched.
- Update (effective at the clock edge):
  - Hit, taken: ctr saturating +1 (max all-ones); target overwritten.
  - Hit, not taken: ctr saturating -1 (min 0); target unchanged.
  - Hit, either outcome: PLRU touched.
  - Miss, taken: allocate the lowest-index invalid way; if none, the PLRU victim. Write valid = 1, tag, target, ctr = 1<<(CTR_BITS-1) (weakly taken); touch PLRU.
  - Miss, not taken: no state change.
- PLRU convention:
  - Node bit 0 means the victim is in the lower half.
  - A touch sets each node on the accessed path to point away from the accessed way.
  - Root = bit 0; children of node k are 2k+1 and 2k+2.
- Same cycle lookup and update:
  - Lookup sees pre-update state (read-before-write).
  - If both touch the same set, the update's PLRU touch wins.
- Flush FSM, two states:
  - IDLE: flush = 1 -> FLUSH, counter = 0, busy = 1 from the next cycle.
  - FLUSH: each cycle clears the valid bits and PLRU bits of set counter and increments counter. After set SETS-1 -> IDLE; busy = 0 in the cycle after the last clear.
  - Total busy = SETS cycles.
  - While busy: lookups still return pred_valid = 1 with pred_hit = 0; upd_en ignored; flush ignored.
- rst_n low in any state: immediate return to IDLE with everything cleared.
- Counter: IDX bits, no wrap beyond SETS-1.

Test Plan:
(Defaults: SETS=8, WAYS=4, CTR_BITS=2; index = pc[3:1].)
1. Reset, then lookup 0x3000 -> next cycle: pred_valid=1, hit=0, taken=0, target=0x0000; no lookup -> pred_valid=0.
2. Update 0x3000 -> 0x3040 taken; lookup 0x3000 -> hit=1, taken=1 (ctr=2'b10), target=0x3040. Lookup 0x3002 (different set) -> hit=0.
3. Two not-taken updates on 0x3000, then lookup -> hit=1, taken=0 (ctr=00). A third not-taken keeps ctr=00. Not-taken update 0x3100 (miss) -> later lookup 0x3100 hit=0.
4. Taken updates 0x3000, 0x3010, 0x3020, 0x3030 (set 0, ways 0-3); lookup 0x3000; taken update 0x3040 -> evicts way 2. Lookups: 0x3020 hit=0; 0x3000, 0x3010, 0x3030, 0x3040 hit=1.
5. Populate sets 0 and 5; pulse flush -> busy=1 for exactly 8 cycles. Lookups during busy -> hit=0; update 0x3000 during busy -> ignored. After busy falls, all prior PCs miss.
6. Same-cycle lookup and taken update of new PC 0x300A -> lookup returns hit=0; next lookup 0x300A -> hit=1. Drop rst_n mid-flush (cycle 3) -> busy=0 and pred_*=0 asynchronously; after release, all lookups miss.
